cache_axi_wr_bridge: RTL and testbench

- Downstream of the cache fetch controller's writeback path: converts its line-writeback request/stream (wr_req/wr_gnt, byte length, data beats, wr_done) into AXI4 write bursts (AW/W/B).
- Single outstanding request; splits long or 4KB-crossing transfers into multiple INCR bursts.
- awsize is fixed at log2(DATA_WIDTH/8) and awburst is INCR; both are tied off at the top level and not ported here.

---
 rtl/cache_axi_wr_bridge.sv | 109 ++++++++++
 tb/tb_cache_axi_wr_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_wr_bridge.sv
// cache_axi_wr_bridge: turns a cache line-writeback request/stream into AXI4 INCR write bursts
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_req/wr_gnt               client request handshake, wr_addr/wr_len sampled on grant
//   wr_data/wr_valid/wr_ready   client beat stream, passed straight through to W
//   wr_last                     client final-beat marker, only checked against the beat count
//   wr_done/wr_err              one-cycle completion pulse, sticky error for the transfer
//   aw*/w*/b*                   AXI4 write address, data and response channels
module cache_axi_wr_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    output logic                  wr_gnt,
    input  logic [15:0]           wr_len,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_last,
    output logic                  wr_done,
    output logic                  wr_err,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wlast,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int LB  = $clog2(BPB);
    localparam int RW  = 16 - LB;
    localparam logic [2:0] IDLE = 3'd0, AW = 3'd1, DATA = 3'd2, RESP = 3'd3, DONE = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [RW-1:0]         rem;
    logic [12:0]           blen, bcnt, page, blen_c;
    logic [16:0]           lim;
    logic                  w_hs;

    // beats left before the next 4KB boundary, then clamp by MAX_BURST and remaining beats;
    // addr and rem are stable throughout AW, so the value is captured on the AW handshake
    assign page   = (13'h1000 - 13'(addr[11:0])) >> LB;
    assign lim    = ({4'b0, page} < 17'(MAX_BURST)) ? {4'b0, page} : 17'(MAX_BURST);
    assign blen_c = 13'((17'(rem) < lim) ? 17'(rem) : lim);

    assign wr_gnt   = state == IDLE && rst_n;
    assign awvalid  = state == AW;
    assign awaddr   = state == AW ? addr : '0;
    assign awlen    = state == AW ? 8'(blen_c - 13'd1) : 8'd0;
    assign wvalid   = state == DATA && wr_valid;
    assign wr_ready = state == DATA && wready;
    assign wdata    = state == DATA ? wr_data : '0;
    assign wlast    = state == DATA && bcnt == blen - 13'd1;
    assign w_hs     = wvalid && wready;
    assign bready   = state == RESP;
    assign wr_done  = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr   <= '0;
            rem    <= '0;
            blen   <= '0;
            bcnt   <= '0;
            wr_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (wr_req) begin
                    addr   <= wr_addr & ~ADDR_WIDTH'(BPB - 1);
                    rem    <= RW'(wr_len >> LB);
                    wr_err <= 1'b0;
                    state  <= (wr_len >> LB) == 16'd0 ? DONE : AW;
                end
                AW: if (awready) begin
                    blen  <= blen_c;
                    bcnt  <= '0;
                    state <= DATA;
                end
                DATA: if (w_hs) begin
                    bcnt <= bcnt + 13'd1;
                    rem  <= rem - RW'(1);
                    // the beat count is authoritative; a misplaced client marker only flags an error
                    if (wr_last != (rem == RW'(1)))
                        wr_err <= 1'b1;
                    if (wlast)
                        state <= RESP;
                end
                RESP: if (bvalid) begin
                    if (bresp != 2'b00)
                        wr_err <= 1'b1;
                    addr  <= addr + (ADDR_WIDTH'(blen) << LB);
                    state <= rem != '0 ? AW : DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_wr_bridge.sv
// tb_cache_axi_wr_bridge: scoreboard bench, expected AW/W traffic queued at stimulus time and popped on AXI handshakes
module tb_cache_axi_wr_bridge;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    logic        clk, rst_n;
    logic        wr_req, wr_gnt, wr_valid, wr_ready, wr_last, wr_done, wr_err;
    logic [15:0] wr_len;
    logic [31:0] wr_addr, wr_data, awaddr, wdata;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [7:0]  awlen;
    logic [1:0]  bresp;
    logic        any_out;

    aw_t         exp_aw[$];
    logic [31:0] exp_w[$];
    int checks = 0, errors = 0;
    int cyc = 0, b_cyc = 0, done_cnt = 0, bnum = 0, bad_burst = -1;
    int aw_delay = 0, aw_wait = 0, beats_left = 0;
    bit bpend = 0, throttle = 0;

    cache_axi_wr_bridge dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_len(wr_len),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_last(wr_last), .wr_done(wr_done), .wr_err(wr_err), .awvalid(awvalid),
        .awready(awready), .awaddr(awaddr), .awlen(awlen), .wvalid(wvalid), .wready(wready),
        .wdata(wdata), .wlast(wlast), .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    assign any_out = |{wr_gnt, wr_ready, wr_done, wr_err, awvalid, awaddr, awlen,
                       wvalid, wdata, wlast, bready};

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // independent burst split: min(remaining, 256, beats to 4KB page end)
    function automatic void model(input logic [31:0] a, input logic [15:0] len);
        int rem, b, pg;
        aw_t e;
        rem = int'(len) / 4;
        a = a & ~32'h3;
        while (rem > 0) begin
            pg = (4096 - int'(a[11:0])) / 4;
            b = rem < 256 ? rem : 256;
            if (pg < b) b = pg;
            e.addr = a;
            e.len  = 8'(b - 1);
            exp_aw.push_back(e);
            a = a + 32'(b * 4);
            rem = rem - b;
        end
    endfunction

    // AXI slave: drives ready/response at negedge, evaluates handshakes just before posedge
    initial begin
        aw_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_wait = 0; beats_left = 0; bpend = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
            end else begin
                awready = aw_wait >= aw_delay;
                wready  = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
                bvalid  = bpend;
                bresp   = bnum == bad_burst ? 2'b10 : 2'b00;
                #1;
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) check("aw_queue", exp_aw.size(), 1);
                    else begin
                        e = exp_aw.pop_front();
                        check("awaddr", awaddr, e.addr);
                        check("awlen", awlen, e.len);
                    end
                    beats_left = int'(awlen) + 1;
                    aw_wait = 0;
                end else if (awvalid) aw_wait++;
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) check("w_queue", exp_w.size(), 1);
                    else check("wdata", wdata, exp_w.pop_front());
                    check("wlast", wlast, beats_left == 1);
                    beats_left--;
                    if (wlast) bpend = 1;
                end
                if (bvalid && bready) begin
                    bpend = 0;
                    bnum++;
                    b_cyc = cyc;
                end
                if (wr_done) done_cnt++;
            end
        end
    end

    task automatic xfer(input logic [31:0] a, input logic [15:0] len, input bit bad_last, input bit exp_err);
        logic [31:0] d[$];
        int nb, k, t, dn0;
        bit granted, gsamp, seen;
        nb = int'(len) / 4; k = 0; t = 0; granted = 0; gsamp = 0; seen = 0;
        model(a, len);
        for (int i = 0; i < nb; i++) begin
            d.push_back($urandom);
            exp_w.push_back(d[i]);
        end
        dn0 = done_cnt;
        wr_addr = a;
        wr_len = len;
        while (!seen && t < 5000) begin
            @(negedge clk);
            wr_req   = !granted;
            wr_valid = granted && k < nb && (!throttle || $urandom_range(0, 2) != 0);
            wr_data  = k < nb ? d[k] : 32'h0;
            wr_last  = bad_last ? (k == 0) : (k == nb - 1);
            #1;
            if (gsamp) begin
                check("err_clr", wr_err, 0);
                gsamp = 0;
            end
            if (!granted && wr_req && wr_gnt) begin
                granted = 1;
                gsamp = 1;
            end
            if (wr_valid && wr_ready) k++;
            if (wr_done) seen = 1;
            t++;
        end
        wr_valid = 0;
        wr_last = 0;
        wr_req = 0;
        check("done_seen", seen, 1);
        check("beats", k, nb);
        check("err_done", wr_err, exp_err);
        if (nb > 0) check("done_lat", cyc - b_cyc, 1);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", done_cnt - dn0, 1);
        check("err_hold", wr_err, exp_err);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d[$];
        int k, t;
        rst_n = 0; wr_req = 0; wr_len = 0; wr_addr = 0; wr_data = 0; wr_valid = 0; wr_last = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_outs", any_out, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("idle_gnt", wr_gnt, 1);
        check("idle_awvalid", awvalid, 0);
        check("idle_wr_ready", wr_ready, 0);

        aw_delay = 3;
        xfer(32'h1000, 128, 0, 0);
        aw_delay = 0;
        xfer(32'h0000, 2048, 0, 0);
        xfer(32'h0FC0, 128, 0, 0);
        throttle = 1;
        xfer(32'h4000, 128, 0, 0);
        throttle = 0;
        bad_burst = bnum;
        xfer(32'h0000, 2048, 0, 1);
        bad_burst = -1;
        xfer(32'h0100, 16, 0, 0);
        xfer(32'h0200, 32, 1, 1);
        xfer(32'h0300, 0, 0, 0);
        xfer(32'h5006, 16, 0, 0);

        // reset in the middle of a burst
        model(32'h2000, 128);
        for (int i = 0; i < 32; i++) begin
            d.push_back($urandom);
            exp_w.push_back(d[i]);
        end
        wr_addr = 32'h2000;
        wr_len = 128;
        k = 0; t = 0;
        while (k < 5 && t < 200) begin
            @(negedge clk);
            wr_req = t == 0;
            wr_valid = t > 0;
            wr_data = d[k];
            #1;
            if (wr_valid && wr_ready) k++;
            t++;
        end
        check("pre_rst_beats", k, 5);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_async", any_out, 0);
        @(negedge clk);
        wr_valid = 0;
        wr_req = 0;
        #1;
        check("rst_next", any_out, 0);
        exp_aw.delete();
        exp_w.delete();
        @(negedge clk);
        rst_n = 1;
        #1;
        check("gnt_after_rst", wr_gnt, 1);
        xfer(32'h3000, 64, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
